// File: rtl/scroll_pkg.sv
// Shared definitions for the scroll speed Avalon-MM master: state encoding,
// bus width, default speed bounds and the saturating step helper.
package scroll_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_READ   = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    localparam int AVM_DATA_W     = 32;
    localparam int SPEED_INIT_DEF = 16;
    localparam int SPEED_MIN_DEF  = 1;
    localparam int SPEED_MAX_DEF  = 255;
    localparam int TIMEOUT_DEF    = 255;

    function automatic int unsigned sat_step(input int unsigned cur, input logic up,
                                             input int unsigned lo, input int unsigned hi);
        if (up)
            return (cur >= hi) ? cur : cur + 1;
        else
            return (cur <= lo) ? cur : cur - 1;
    endfunction

endpackage

// File: rtl/scroll_req_latch.sv
// One-deep pending slot for speed key pulses: merges new pulses with a held
// request, lets the latest pulse win and cancels on opposite direction.
module scroll_req_latch (
    input  logic clock,
    input  logic reset,
    input  logic speedup,
    input  logic speeddown,
    input  logic consume,
    output logic req_valid,
    output logic req_up
);

    logic pend_valid;
    logic pend_up;
    logic pulse;

    // Simultaneous up and down pulses cancel at the source.
    assign pulse     = speedup ^ speeddown;
    assign req_valid = pend_valid | pulse;
    assign req_up    = pend_valid ? pend_up : speedup;

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_up    <= 1'b0;
        end else if (consume) begin
            // Held request goes out first; a coincident pulse waits in the slot.
            pend_valid <= pend_valid & pulse;
            pend_up    <= speedup;
        end else if (pulse) begin
            if (pend_valid && (pend_up != speedup)) begin
                pend_valid <= 1'b0;
            end else begin
                pend_valid <= 1'b1;
                pend_up    <= speedup;
            end
        end
    end

endmodule

// File: rtl/scroll_avalon_master.sv
// Avalon-MM master that turns speed key pulses into saturating writes of the
// scroll speed register. Define READBACK_CHECK_EN to verify each write by read-back.
module scroll_avalon_master
    import scroll_pkg::*;
#(
    parameter int SPEED_W    = 8,
    parameter int SPEED_INIT = SPEED_INIT_DEF,
    parameter int SPEED_MIN  = SPEED_MIN_DEF,
    parameter int SPEED_MAX  = SPEED_MAX_DEF,
    parameter int ADDR_W     = 4,
    parameter int REG_ADDR   = 0,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  speedup,
    input  logic                  speeddown,
    input  logic                  clear_error,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic                  avm_read,
    output logic [AVM_DATA_W-1:0] avm_writedata,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    output logic [SPEED_W-1:0]    speed,
    output logic                  busy,
    output logic                  error
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t             state;
    logic [SPEED_W-1:0] target_q;
    logic [SPEED_W-1:0] target_nxt;
    logic [TMR_W-1:0]   tmr;
    logic               tmr_done;
    logic               req_valid;
    logic               req_up;
    logic               consume;

    assign avm_address = ADDR_W'(REG_ADDR);
    assign busy        = (state != S_IDLE);
    assign consume     = (state == S_IDLE);
    assign tmr_done    = (tmr == '0);
    assign target_nxt  = SPEED_W'(sat_step(32'(speed), req_up, SPEED_MIN, SPEED_MAX));

    scroll_req_latch u_req_latch (
        .clock     (clock),
        .reset     (reset),
        .speedup   (speedup),
        .speeddown (speeddown),
        .consume   (consume),
        .req_valid (req_valid),
        .req_up    (req_up)
    );

`ifndef READBACK_CHECK_EN
    assign avm_read = 1'b0;
    logic unused_rd;
    assign unused_rd = ^{avm_readdata, avm_readdatavalid};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            speed         <= SPEED_W'(SPEED_INIT);
            target_q      <= SPEED_W'(SPEED_INIT);
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            error         <= 1'b0;
            tmr           <= '0;
`ifdef READBACK_CHECK_EN
            avm_read      <= 1'b0;
`endif
        end else begin
            // Later error sets in this block override the clear.
            if (clear_error)
                error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && (target_nxt != speed)) begin
                        state         <= S_WRITE;
                        target_q      <= target_nxt;
                        avm_write     <= 1'b1;
                        avm_writedata <= AVM_DATA_W'(target_nxt);
                        tmr           <= TMR_LOAD;
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        speed     <= target_q;
                        tmr       <= TMR_LOAD;
`ifdef READBACK_CHECK_EN
                        state     <= S_READ;
                        avm_read  <= 1'b1;
`else
                        state     <= S_IDLE;
`endif
                    end else if (tmr_done) begin
                        avm_write <= 1'b0;
                        error     <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`ifdef READBACK_CHECK_EN
                S_READ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= S_RDWAIT;
                        tmr      <= TMR_LOAD;
                    end else if (tmr_done) begin
                        avm_read <= 1'b0;
                        error    <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RDWAIT: begin
                    if (avm_readdatavalid) begin
                        if (avm_readdata != AVM_DATA_W'(speed))
                            error <= 1'b1;
                        state <= S_IDLE;
                    end else if (tmr_done) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scroll_avalon_master.md
Name: scroll_avalon_master

Overview:
- Avalon-MM master; the initiator end of the scroll speed register slave.
- Turns debounced speed-up/speed-down key pulses into saturating speed updates.
- Writes each new speed to the scroll register and optionally reads it back to verify.
- Sits between the board key debouncers and the Qsys interconnect. Replaces software polling for speed control.

Parameters:
- SPEED_W, 8, width of speed value, zero-extended into 32-bit writedata.
- SPEED_INIT, 16, speed value after reset.
- SPEED_MIN, 1, lower saturation bound.
- SPEED_MAX, 255, upper saturation bound.
- ADDR_W, 4, avm_address width.
- REG_ADDR, 0, address of scroll register in slave.
- TIMEOUT, 255, max cycles a command or read response may stall before abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- speedup  in  1  single-cycle request pulse: speed+1.
- speeddown  in  1  single-cycle request pulse: speed-1.
- clear_error  in  1  clears sticky error.
- avm_address  out  ADDR_W  always REG_ADDR.
- avm_write  out  1  write command.
- avm_read  out  1  read command.
- avm_writedata  out  32  {zeros, target speed}.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read response valid.
- speed  out  SPEED_W  last speed accepted by the slave.
- busy  out  1  state != IDLE.
- error  out  1  sticky: timeout or readback mismatch.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: speed=SPEED_INIT; avm_write=avm_read=0; error=0; busy=0; state IDLE; pending cleared. Reset mid-transaction drops the command immediately, with no completion.
- States: IDLE, WRITE, READ, RDWAIT.
- IDLE:
  - Request source is a new pulse or the pending slot; pending has priority.
  - target = speed±1, saturated to [SPEED_MIN,SPEED_MAX].
  - If target==speed, the request is dropped and no bus cycle occurs.
  - Otherwise, next cycle: WRITE with avm_write=1 and avm_writedata=target.
- speedup and speeddown high in the same cycle: both ignored.
- WRITE:
  - avm_write and avm_writedata are held stable while avm_waitrequest=1.
  - Accept is the cycle with avm_write=1 and avm_waitrequest=0. On accept:
    - speed<=target the following cycle.
    - avm_write deasserts.
    - Next state is READ (with READBACK_CHECK_EN) or IDLE (without).
- READ:
  - avm_read=1 is held until avm_waitrequest=0, then deasserts. Next state RDWAIT.
- RDWAIT:
  - Waits for avm_readdatavalid.
  - If readdata != zero-extended speed, error<=1.
  - Next state IDLE.
- Timeout:
  - Per-state counter of cycles spent in WRITE, READ or RDWAIT, reset on each state entry.
  - Reaching TIMEOUT drops the command: error<=1, state IDLE.
  - On a WRITE timeout, speed is unchanged.
- Pulses while busy:
  - Stored in a one-deep pending slot; the latest pulse overwrites.
  - An opposite-direction pulse arriving while pending is set clears the slot (net zero).
- Bus arbitration: avm_write and avm_read are never asserted together.
- Error clearing: clear_error clears error. If a new error event occurs in the same cycle, set wins.
- Latency (zero-wait slave): pulse at cycle n -> avm_write at n+1 -> speed updated at n+2.

Optional Feature:
- Macro READBACK_CHECK_EN.
- Defined: read-after-write verify via READ/RDWAIT; a mismatch sets error.
- Undefined: READ/RDWAIT are not built; avm_read is tied to 0; WRITE returns to IDLE; error is set only by timeout.

Decomposition:
- Package scroll_pkg holds:
  - state encoding (IDLE/WRITE/READ/RDWAIT);
  - Avalon data width 32;
  - default SPEED_INIT/MIN/MAX;
  - TIMEOUT default.
- One natural sub-module, scroll_req_latch: the pending slot plus pulse merge/cancel logic. Outputs req_valid and req_up, with a consume input.

Test Plan:
- Zero-wait slave, speedup pulse after reset -> avm_write 1 cycle with writedata=0x11; speed=17 two cycles after pulse; with READBACK_CHECK_EN, one read, error=0.
- avm_waitrequest held 5 cycles during write -> avm_write and writedata=0x11 stable all 6 cycles; speed=17 only after accept.
- speed=255, speedup pulse -> no avm_write; speed stays 255. Same at 1 with speeddown.
- Pulses during busy: speedup, speedup, speeddown while WRITE stalled -> no follow-up write; speed=17 final.
- avm_waitrequest stuck high -> abort after 255 cycles; error=1; speed unchanged; clear_error -> error=0.
- READBACK_CHECK_EN, slave returns 0x12 for written 0x11 -> error=1 one cycle after avm_readdatavalid; state IDLE.
